ped_request_unit: RTL and testbench

Pedestrian push-button front end for the two-road intersection controller. It debounces the A/B crossing buttons and latches each press as a pending request. It drives the controller's `Sa`/`Sb` request inputs until the controller acknowledges by entering yellow. It then decodes the controller's lamp outputs and drives per-crossing WALK / DON'T-WALK signals for as long as the road being crossed is held red.

---
 rtl/ped_pkg.sv | 16 +
 rtl/ped_debounce.sv | 49 ++++
 rtl/ped_request_unit.sv | 176 +++++++++++++++++
 tb/tb_ped_request_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and reset constants for the pedestrian request unit.
package ped_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        ACKED   = 3'd2,
        WALK    = 3'd3,
        FLASH   = 3'd4
    } ped_state_t;

    localparam logic WALK_RST      = 1'b0;
    localparam logic DONT_WALK_RST = 1'b1;
    localparam int   NUM_CH        = 2;

endpackage

// File: rtl/ped_debounce.sv
// Push-button front end: 2-flop synchronizer, debounce counter and a
// one-clock press pulse on each rising edge of the debounced level.
module ped_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d   = ~deb_q;
                press_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: debounced A/B buttons, per-crossing request FSMs
// and WALK/DON'T-WALK drive. Optional flashing tail enabled by PED_FLASH_EN.
//
//   state   | meaning
//   IDLE    | no request outstanding, DON'T-WALK steady
//   PENDING | request latched, Sx asserted to the controller
//   ACKED   | controller entered yellow, waiting for the crossed road to go red
//   WALK    | steady WALK, walk counter running
//   FLASH   | walk tail, DON'T-WALK flashing (PED_FLASH_EN only)
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 16,
    parameter int FLASH_CYCLES    = 8,
    parameter int FLASH_HALF      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_a,
    input  logic btn_b,
    input  logic Ra,
    input  logic Ya,
    input  logic Ga,
    input  logic Rb,
    input  logic Yb,
    input  logic Gb,
    output logic Sa,
    output logic Sb,
    output logic walk_a,
    output logic walk_b,
    output logic dont_walk_a,
    output logic dont_walk_b
);

    localparam int WCNT_W = $clog2(WALK_CYCLES) + 1;

    if (DEBOUNCE_CYCLES < 1 || WALK_CYCLES <= FLASH_CYCLES || FLASH_HALF < 1) begin : g_param_check
        $error("ped_request_unit: illegal parameter combination");
    end

    logic [NUM_CH-1:0] press, ack, red;
    logic              unused_green;

    ped_state_t                    state_q [NUM_CH];
    ped_state_t                    state_d [NUM_CH];
    logic [NUM_CH-1:0][WCNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]             s_q, walk_q, dw_q;

`ifdef PED_FLASH_EN
    localparam int HCNT_W = $clog2(FLASH_HALF) + 1;
    logic [NUM_CH-1:0][HCNT_W-1:0] fh_q, fh_d;
    logic [NUM_CH-1:0]             ph_q, ph_d;
`endif

    ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_a),
        .press_o(press[0])
    );

    ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_b),
        .press_o(press[1])
    );

    // Yellow on the crossed road is the acknowledge; red without yellow is safe to cross.
    assign ack          = {Yb, Ya};
    assign red          = {Rb & ~Yb, Ra & ~Ya};
    assign unused_green = Ga ^ Gb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PED_FLASH_EN
        fh_d    = fh_q;
        ph_d    = ph_q;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (state_q[ch])
                IDLE: begin
                    if (press[ch]) state_d[ch] = PENDING;
                end
                PENDING: begin
                    if (ack[ch]) state_d[ch] = ACKED;
                end
                ACKED: begin
                    if (red[ch]) begin
                        state_d[ch] = WALK;
                        cnt_d[ch]   = WCNT_W'(WALK_CYCLES - 1);
                    end
                end
                WALK: begin
                    if (!red[ch]) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end else begin
`ifdef PED_FLASH_EN
                        if (cnt_q[ch] == WCNT_W'(FLASH_CYCLES)) begin
                            state_d[ch] = FLASH;
                            fh_d[ch]    = HCNT_W'(FLASH_HALF - 1);
                            ph_d[ch]    = 1'b0;
                        end
                        if (cnt_q[ch] != '0) cnt_d[ch] = cnt_q[ch] - WCNT_W'(1);
`else
                        if (cnt_q[ch] == '0) state_d[ch] = IDLE;
                        else                 cnt_d[ch]   = cnt_q[ch] - WCNT_W'(1);
`endif
                    end
                end
`ifdef PED_FLASH_EN
                FLASH: begin
                    if (!red[ch] || cnt_q[ch] == '0) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] - WCNT_W'(1);
                        if (fh_q[ch] == '0) begin
                            fh_d[ch] = HCNT_W'(FLASH_HALF - 1);
                            ph_d[ch] = ~ph_q[ch];
                        end else begin
                            fh_d[ch] = fh_q[ch] - HCNT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the registered state, one clock behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) state_q[ch] <= IDLE;
            cnt_q  <= '0;
            s_q    <= '0;
            walk_q <= {NUM_CH{WALK_RST}};
            dw_q   <= {NUM_CH{DONT_WALK_RST}};
`ifdef PED_FLASH_EN
            fh_q   <= '0;
            ph_q   <= '0;
`endif
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                s_q[ch]     <= (state_q[ch] == PENDING);
                walk_q[ch]  <= (state_q[ch] == WALK);
`ifdef PED_FLASH_EN
                dw_q[ch]    <= (state_q[ch] == FLASH) ? ph_q[ch] : (state_q[ch] != WALK);
`else
                dw_q[ch]    <= (state_q[ch] != WALK);
`endif
            end
            cnt_q <= cnt_d;
`ifdef PED_FLASH_EN
            fh_q  <= fh_d;
            ph_q  <= ph_d;
`endif
        end
    end

    assign Sa          = s_q[0];
    assign Sb          = s_q[1];
    assign walk_a      = walk_q[0];
    assign walk_b      = walk_q[1];
    assign dont_walk_a = dw_q[0];
    assign dont_walk_b = dw_q[1];

endmodule

// File: tb/tb_ped_request_unit.sv
// Self-checking bench for ped_request_unit: per-cycle scoreboard of
// stimulus and expected {Sa,Sb,walk_a,walk_b,dont_walk_a,dont_walk_b}.
module tb_ped_request_unit;

    logic clk;
    logic reset, btn_a, btn_b, Ra, Ya, Ga, Rb, Yb, Gb;
    logic Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b;

    ped_request_unit #(
        .DEBOUNCE_CYCLES(4),
        .WALK_CYCLES    (16),
        .FLASH_CYCLES   (8),
        .FLASH_HALF     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_a      (btn_a),
        .btn_b      (btn_b),
        .Ra         (Ra),
        .Ya         (Ya),
        .Ga         (Ga),
        .Rb         (Rb),
        .Yb         (Yb),
        .Gb         (Gb),
        .Sa         (Sa),
        .Sb         (Sb),
        .walk_a     (walk_a),
        .walk_b     (walk_b),
        .dont_walk_a(dont_walk_a),
        .dont_walk_b(dont_walk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] stim;
        logic [5:0] exp;
        string      tag;
    } step_t;

    step_t sbq[$];
    int    checks = 0;
    int    errors = 0;

    // stimulus being scheduled and expected outputs after the edge that samples it
    logic s_rst, s_ba, s_bb, s_ra, s_ya, s_rb, s_yb;
    logic e_sa, e_sb, e_wa, e_wb, e_dwa, e_dwb;

    task automatic add(input int n, input string tag);
        step_t st;
        st.stim = {s_rst, s_ba, s_bb, s_ra, s_ya, s_rb, s_yb};
        st.exp  = {e_sa, e_sb, e_wa, e_wb, e_dwa, e_dwb};
        st.tag  = tag;
        for (int i = 0; i < n; i++) sbq.push_back(st);
    endtask

    task automatic test_reset();
        step_t st;
        logic [5:0] got;
        s_rst = 1; s_ba = 0; s_bb = 0; s_ra = 0; s_ya = 0; s_rb = 0; s_yb = 0;
        e_sa = 0; e_sb = 0; e_wa = 0; e_wb = 0; e_dwa = 1; e_dwb = 1;
        add(3, "reset_values");
        s_rst = 0;
        add(3, "idle_after_reset");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    task automatic test_press_ack();
        step_t st;
        logic [5:0] got;
        s_ba = 1;
        add(7, "press_latency_sa_low");
        e_sa = 1;
        add(5, "press_sa_high");
        s_ya = 1;
        add(1, "ack_sample_edge");
        e_sa = 0;
        add(1, "ack_sa_fall");
        s_ya = 0;
        add(4, "acked_sa_low");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    task automatic test_walk();
        step_t st;
        logic [5:0] got;
        s_ra = 1; s_ya = 0;
        add(1, "walk_entry_edge");
        e_wa = 1; e_dwa = 0;
`ifdef PED_FLASH_EN
        add(8, "walk_steady");
        e_wa = 0;
        for (int k = 0; k < 2; k++) begin
            e_dwa = 0; add(2, "flash_low");
            e_dwa = 1; add(2, "flash_high");
        end
`else
        add(16, "walk_steady");
`endif
        e_wa = 0; e_dwa = 1;
        add(6, "walk_done_idle");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    task automatic test_bounce();
        step_t st;
        logic [5:0] got;
        s_bb = 1;
        add(3, "bounce_high");
        s_bb = 0;
        add(15, "bounce_no_sb");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    task automatic test_safety_abort();
        step_t st;
        logic [5:0] got;
        s_ba = 0; s_ra = 0;
        add(8, "release_a");
        s_ba = 1;
        add(7, "press2_latency");
        e_sa = 1;
        add(2, "press2_sa_high");
        s_ya = 1;
        add(1, "ack2_sample_edge");
        e_sa = 0; s_ya = 0;
        add(1, "ack2_sa_fall");
        s_ra = 1;
        add(1, "walk2_entry_edge");
        e_wa = 1; e_dwa = 0;
        add(3, "walk2_steady");
        s_ra = 0;
        add(1, "abort_sample_edge");
        e_wa = 0; e_dwa = 1;
        add(3, "abort_outputs");
        s_ra = 1;
        add(6, "no_rewalk_after_abort");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    task automatic test_absorb_indep();
        step_t st;
        logic [5:0] got;
        s_ba = 0; s_ra = 0;
        add(8, "release_a_again");
        s_ba = 1; s_bb = 1;
        add(7, "dual_press_latency");
        e_sa = 1; e_sb = 1;
        add(3, "dual_press_high");
        s_ba = 0;
        add(8, "release_in_pending");
        s_ba = 1;
        add(10, "absorbed_second_press");
        s_ya = 1;
        add(1, "ack3_sample_edge");
        e_sa = 0; s_ya = 0;
        add(12, "sa_no_rerise");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        step_t st;
        logic [5:0] got;
        s_ra = 1;
        add(1, "walk3_entry_edge");
        e_wa = 1; e_dwa = 0;
        add(4, "walk3_steady");
        s_rst = 1; s_ba = 0; s_bb = 0;
        e_sa = 0; e_sb = 0; e_wa = 0; e_dwa = 1;
        add(1, "reset_mid_walk_edge");
        s_rst = 0;
        add(20, "no_walk_after_reset");
        while (sbq.size() != 0) begin
            st = sbq.pop_front();
            {reset, btn_a, btn_b, Ra, Ya, Rb, Yb} = st.stim;
            @(posedge clk); #1;
            got = {Sa, Sb, walk_a, walk_b, dont_walk_a, dont_walk_b};
            checks++;
            if (got !== st.exp) begin
                errors++;
                $display("FAIL %s: got outs=%b expected %b", st.tag, got, st.exp);
            end
        end
    endtask

    initial begin
        reset = 1; btn_a = 0; btn_b = 0;
        Ra = 0; Ya = 0; Ga = 0; Rb = 0; Yb = 0; Gb = 0;
        test_reset();
        test_press_ack();
        test_walk();
        test_bounce();
        test_safety_abort();
        test_absorb_indep();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
